// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_arb_pkg;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_LOAD  = 1'b1
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
   } resp_tag_t;

   localparam int STARVE_CNT_W     = 4;
   localparam int PERF_CNT_W       = 16;
   localparam int MAX_READ_LATENCY = 4;

   localparam logic [STARVE_CNT_W-1:0] STARVE_SAT = '1;

endpackage

// File: rtl/imem_arb_resp_pipe.sv
// Fixed-depth {valid, owner} shift register that tracks in-flight reads.
module imem_arb_resp_pipe
   import imem_arb_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic      clk,
   input  logic      reset_n,
   input  resp_tag_t tag_in,
   output resp_tag_t tag_out
);

   resp_tag_t stage_q [DEPTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '{valid: 1'b0, owner: OWN_FETCH};
         end
      end else begin
         stage_q[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/imem_arbiter.sv
// Two-port arbiter in front of a single-port instruction memory.
// Optional perf counters are enabled with the IMEM_ARB_PERF_EN macro.
module imem_arbiter
   import imem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  f_req,
   input  logic [ADDR_WIDTH-1:0] f_addr,
   output logic                  f_gnt,
   output logic                  f_rvalid,
   output logic [DATA_WIDTH-1:0] f_rdata,
   input  logic                  l_req,
   input  logic                  l_we,
   input  logic [ADDR_WIDTH-1:0] l_addr,
   input  logic [DATA_WIDTH-1:0] l_wdata,
   output logic                  l_gnt,
   output logic                  l_rvalid,
   output logic [DATA_WIDTH-1:0] l_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [PERF_CNT_W-1:0] perf_f_grants,
   output logic [PERF_CNT_W-1:0] perf_l_grants,
   output logic [PERF_CNT_W-1:0] perf_conflicts
);

   localparam logic [STARVE_CNT_W-1:0] STARVE_THR = STARVE_CNT_W'(STARVE_LIMIT);

   logic [STARVE_CNT_W-1:0] starve_cnt_q;
   logic [STARVE_CNT_W-1:0] starve_cnt_d;
   logic                    load_pri;
   resp_tag_t               tag_in;
   resp_tag_t               tag_out;

   // Grants are gated by reset_n so nothing reaches the macro while in reset.
   always_comb begin
      load_pri  = (starve_cnt_q >= STARVE_THR);
      l_gnt     = reset_n & l_req & (~f_req | load_pri);
      f_gnt     = reset_n & f_req & ~(l_req & load_pri);
      mem_en    = f_gnt | l_gnt;
      mem_we    = l_gnt & l_we;
      mem_addr  = '0;
      mem_wdata = '0;
      if (l_gnt) begin
         mem_addr  = l_addr;
         mem_wdata = l_wdata;
      end else if (f_gnt) begin
         mem_addr  = f_addr;
      end
   end

   always_comb begin
      starve_cnt_d = '0;
      if (l_req && !l_gnt) begin
         starve_cnt_d = (starve_cnt_q == STARVE_SAT) ? starve_cnt_q
                                                     : starve_cnt_q + STARVE_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

   always_comb begin
      tag_in.valid = mem_en & ~mem_we;
      tag_in.owner = l_gnt ? OWN_LOAD : OWN_FETCH;
   end

   imem_arb_resp_pipe #(
      .DEPTH (READ_LATENCY)
   ) u_resp_pipe (
      .clk     (clk),
      .reset_n (reset_n),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   assign f_rvalid = tag_out.valid & (tag_out.owner == OWN_FETCH);
   assign l_rvalid = tag_out.valid & (tag_out.owner == OWN_LOAD);
   assign f_rdata  = mem_rdata;
   assign l_rdata  = mem_rdata;

`ifdef IMEM_ARB_PERF_EN
   logic [PERF_CNT_W-1:0] perf_f_q;
   logic [PERF_CNT_W-1:0] perf_l_q;
   logic [PERF_CNT_W-1:0] perf_c_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_f_q <= '0;
         perf_l_q <= '0;
         perf_c_q <= '0;
      end else begin
         if (f_gnt) perf_f_q <= perf_f_q + PERF_CNT_W'(1);
         if (l_gnt) perf_l_q <= perf_l_q + PERF_CNT_W'(1);
         if (f_req && l_req) perf_c_q <= perf_c_q + PERF_CNT_W'(1);
      end
   end

   assign perf_f_grants  = perf_f_q;
   assign perf_l_grants  = perf_l_q;
   assign perf_conflicts = perf_c_q;
`else
   assign perf_f_grants  = '0;
   assign perf_l_grants  = '0;
   assign perf_conflicts = '0;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: directed scenarios followed by random traffic.
module tb_imem_arbiter;

   localparam int RL = 3;
   localparam int SL = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        f_req, l_req, l_we;
   logic [31:0] f_addr, l_addr, l_wdata;
   logic        f_gnt, f_rvalid, l_gnt, l_rvalid;
   logic [31:0] f_rdata, l_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [15:0] perf_f_grants, perf_l_grants, perf_conflicts;

   imem_arbiter #(
      .ADDR_WIDTH   (32),
      .DATA_WIDTH   (32),
      .READ_LATENCY (RL),
      .STARVE_LIMIT (SL)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .f_req          (f_req),
      .f_addr         (f_addr),
      .f_gnt          (f_gnt),
      .f_rvalid       (f_rvalid),
      .f_rdata        (f_rdata),
      .l_req          (l_req),
      .l_we           (l_we),
      .l_addr         (l_addr),
      .l_wdata        (l_wdata),
      .l_gnt          (l_gnt),
      .l_rvalid       (l_rvalid),
      .l_rdata        (l_rdata),
      .mem_en         (mem_en),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .perf_f_grants  (perf_f_grants),
      .perf_l_grants  (perf_l_grants),
      .perf_conflicts (perf_conflicts)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory: unwritten words read back as addr + 0x1000.
   logic [31:0] mem_arr [256];
   bit          mem_wr  [256];
   logic [31:0] rd_pipe [RL];

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      return mem_wr[a[9:2]] ? mem_arr[a[9:2]] : a + 32'h1000;
   endfunction

   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         mem_arr[mem_addr[9:2]] <= mem_wdata;
         mem_wr[mem_addr[9:2]]  <= 1'b1;
      end
      rd_pipe[0] <= (mem_en && !mem_we) ? mem_read(mem_addr) : 32'h0;
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rdata = rd_pipe[RL-1];

   // Reference model state
   logic [31:0] ref_mem [256];
   bit          ref_wr  [256];
   int          starve;
   logic [15:0] pf, pl, pc;
   bit          last_fg, last_lg;
   bit          done = 0;

   typedef struct {
      int          due;
      bit          own;
      logic [31:0] data;
   } rsp_t;

   typedef struct {
      int          cyc;
      bit          fg, lg, en, we, chk_wdata;
      logic [31:0] addr, wdata;
      logic [15:0] pf, pl, pc;
   } gexp_t;

   rsp_t  sb[$];
   gexp_t gq[$];

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      return ref_wr[a[9:2]] ? ref_mem[a[9:2]] : a + 32'h1000;
   endfunction

   task automatic drive(input logic rst, input logic fr, input logic [31:0] fa,
                        input logic lr, input logic lwe, input logic [31:0] la,
                        input logic [31:0] lwd);
      gexp_t g;
      rsp_t  r;
      @(posedge clk);
      #1;
      reset_n = rst; f_req = fr; f_addr = fa;
      l_req = lr; l_we = lwe; l_addr = la; l_wdata = lwd;
      g.cyc = cyc;
      if (!rst) begin
         sb.delete();
         starve = 0; pf = 0; pl = 0; pc = 0;
         g.fg = 0; g.lg = 0; g.en = 0; g.we = 0; g.chk_wdata = 1;
         g.addr = 0; g.wdata = 0; g.pf = 0; g.pl = 0; g.pc = 0;
      end else begin
         // Loader wins a conflict once it has been refused SL cycles in a row.
         g.lg = lr && (!fr || starve >= SL);
         g.fg = fr && !g.lg;
         g.en = g.fg || g.lg;
         g.we = g.lg && lwe;
         g.addr = g.lg ? la : (g.fg ? fa : 32'h0);
         g.wdata = g.lg ? lwd : 32'h0;
         g.chk_wdata = !g.fg;
`ifdef IMEM_ARB_PERF_EN
         g.pf = pf; g.pl = pl; g.pc = pc;
`else
         g.pf = 0; g.pl = 0; g.pc = 0;
`endif
         if (g.fg) pf++;
         if (g.lg) pl++;
         if (fr && lr) pc++;
         starve = (lr && !g.lg) ? starve + 1 : 0;
         if (g.lg && lwe) begin
            ref_mem[la[9:2]] = lwd;
            ref_wr[la[9:2]]  = 1;
         end else if (g.lg) begin
            r.due = cyc + RL; r.own = 1; r.data = ref_read(la);
            sb.push_back(r);
         end
         if (g.fg) begin
            r.due = cyc + RL; r.own = 0; r.data = ref_read(fa);
            sb.push_back(r);
         end
      end
      last_fg = g.fg;
      last_lg = g.lg;
      gq.push_back(g);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // Monitor: the only process that compares and counts.
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin : mon
      gexp_t       g;
      rsp_t        r;
      logic        ef, el;
      logic [31:0] ed;
      if (done) begin
         chk("sb_drained", 32'(sb.size()), 32'd0);
         chk("gq_drained", 32'(gq.size()), 32'd0);
         $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
         $finish;
      end else begin
         if (gq.size() > 0 && gq[0].cyc == cyc) begin
            g = gq.pop_front();
            chk("f_gnt", 32'(f_gnt), 32'(g.fg));
            chk("l_gnt", 32'(l_gnt), 32'(g.lg));
            chk("mem_en", 32'(mem_en), 32'(g.en));
            chk("mem_we", 32'(mem_we), 32'(g.we));
            chk("mem_addr", mem_addr, g.addr);
            if (g.chk_wdata) chk("mem_wdata", mem_wdata, g.wdata);
            chk("perf_f", 32'(perf_f_grants), 32'(g.pf));
            chk("perf_l", 32'(perf_l_grants), 32'(g.pl));
            chk("perf_c", 32'(perf_conflicts), 32'(g.pc));
         end
         ef = 0; el = 0; ed = 0;
         if (sb.size() > 0 && sb[0].due <= cyc) begin
            r  = sb.pop_front();
            ef = !r.own; el = r.own; ed = r.data;
         end
         chk("f_rvalid", 32'(f_rvalid), 32'(ef));
         chk("l_rvalid", 32'(l_rvalid), 32'(el));
         if (ef) chk("f_rdata", f_rdata, ed);
         if (el) chk("l_rdata", l_rdata, ed);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "bench timeout");
   end

   initial begin
      bit          fp, lp, lwe;
      logic [31:0] fa, la, lwd;
      reset_n = 0; f_req = 1; l_req = 1; l_we = 0;
      f_addr = 0; l_addr = 32'h40; l_wdata = 0;
      starve = 0; pf = 0; pl = 0; pc = 0;

      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);

      // Both requesting from reset release: fetch first, loader after starving.
      lp = 1;
      for (int i = 0; i < 8 && lp; i++) begin
         drive(1'b1, 1'b1, 32'h100 + 32'(i * 4), 1'b1, 1'b0, 32'h40, 32'h0);
         if (last_lg) lp = 0;
      end
      drive(1'b1, 1'b1, 32'h120, 1'b0, 1'b0, 32'h0, 32'h0);

      drive(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b1, 32'h18, 1'b0, 1'b0, 32'h0, 32'h0);
      idle(RL + 1);

      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF);
      drive(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0);
      idle(RL + 1);

      drive(1'b1, 1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h34, 32'h0);
      drive(1'b1, 1'b1, 32'h38, 1'b0, 1'b0, 32'h0, 32'h0);
      idle(RL + 1);

      // Reset lands while a fetch read is in flight.
      drive(1'b1, 1'b1, 32'h50, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      idle(RL + 2);

      fp = 0; lp = 0; fa = 0; la = 0; lwe = 0; lwd = 0;
      for (int n = 0; n < 1500; n++) begin
         if (!fp && $urandom_range(0, 9) < 6) begin
            fp = 1; fa = 32'($urandom_range(0, 63)) * 4;
         end
         if (!lp && $urandom_range(0, 9) < 7) begin
            lp = 1; lwe = 1'($urandom_range(0, 1));
            la = 32'($urandom_range(0, 63)) * 4; lwd = $urandom;
         end
         if ($urandom_range(0, 299) == 0) begin
            drive(1'b0, fp, fa, lp, lwe, la, lwd);
         end else begin
            drive(1'b1, fp, fa, lp, lwe, la, lwd);
            if (last_fg) fp = 0;
            if (last_lg) lp = 0;
         end
      end
      idle(RL + 2);

      @(posedge clk);
      #1;
      done = 1;
   end

endmodule
